sync_fifo_ctrl: RTL and testbench

//  Single-clock, parametrised FIFO: the same-clock counterpart and successor of AsyncFIFO.

---
 rtl/sync_fifo_ctrl.sv | 158 +++++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with configurable width/depth, optional
// first-word-fall-through read, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and a synchronous flush.
//
// Ports:
//   clock           rising-edge clock for all state
//   reset           asynchronous active-low reset
//   io_flush        synchronous clear of contents and sticky flags (highest priority)
//   io_wrReq_en     write request; io_wrReq_data is the word to write
//   io_wrReq_valid  write accepted this cycle (combinational)
//   io_full         count == DEPTH
//   io_almostFull   count >= AF_LEVEL
//   io_rdReq_en     read request (pop)
//   io_rdReq_data   read data (registered for FWFT=0, head of queue for FWFT=1)
//   io_rdReq_valid  io_rdReq_data holds a valid word
//   io_empty        count == 0
//   io_almostEmpty  count <= AE_LEVEL
//   io_count        occupancy 0..DEPTH
//   io_overflow     sticky: write requested while full
//   io_underflow    sticky: read requested while empty
module sync_fifo_ctrl #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter bit          FWFT     = 1'b0,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 1,
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_flush,
  input  logic              io_wrReq_en,
  input  logic [DATA_W-1:0] io_wrReq_data,
  output logic              io_wrReq_valid,
  output logic              io_full,
  output logic              io_almostFull,
  input  logic              io_rdReq_en,
  output logic [DATA_W-1:0] io_rdReq_data,
  output logic              io_rdReq_valid,
  output logic              io_empty,
  output logic              io_almostEmpty,
  output logic [CNT_W-1:0]  io_count,
  output logic              io_overflow,
  output logic              io_underflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AfCnt    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AeCnt    = CNT_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] LastPtr  = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic wr_acc, rd_acc;

  // Status flags come from the registered count only.
  always_comb begin
    io_full        = (count_q == DepthCnt);
    io_empty       = (count_q == '0);
    io_almostFull  = (count_q >= AfCnt);
    io_almostEmpty = (count_q <= AeCnt);
    io_count       = count_q;
    io_overflow    = overflow_q;
    io_underflow   = underflow_q;
  end

  // Accept decisions use the registered flags, so a same-cycle pop never frees room for a
  // push and a same-cycle push never satisfies a pop from empty.
  always_comb begin
    wr_acc         = io_wrReq_en & ~io_full & ~io_flush;
    rd_acc         = io_rdReq_en & ~io_empty & ~io_flush;
    io_wrReq_valid = wr_acc;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (io_flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_d   = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        rd_data_d  = mem[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (io_wrReq_en && io_full) overflow_d = 1'b1;
      if (io_rdReq_en && io_empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= io_wrReq_data;
    end
  end

  // FWFT presents the head directly; it is forced to zero while empty so the output is
  // defined (and zero) out of reset even though storage is not.
  always_comb begin
    if (FWFT) begin
      io_rdReq_valid = ~io_empty;
      io_rdReq_data  = io_empty ? '0 : mem[rd_ptr_q];
    end else begin
      io_rdReq_valid = rd_valid_q;
      io_rdReq_data  = rd_data_q;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;

  localparam bit O = 1'b0;
  localparam bit I = 1'b1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;

  // dut0: FWFT=0 DEPTH=4, dut1: FWFT=1 DEPTH=4, dut2: FWFT=0 DEPTH=5
  logic       d0_wv, d0_full, d0_af, d0_rv, d0_empty, d0_ae, d0_ovf, d0_udf;
  logic [7:0] d0_rd;
  logic [2:0] d0_cnt;
  logic       d1_wv, d1_full, d1_af, d1_rv, d1_empty, d1_ae, d1_ovf, d1_udf;
  logic [7:0] d1_rd;
  logic [2:0] d1_cnt;
  logic       d2_wv, d2_full, d2_af, d2_rv, d2_empty, d2_ae, d2_ovf, d2_udf;
  logic [7:0] d2_rd;
  logic [2:0] d2_cnt;

  logic d0_wv_pre, d1_wv_pre, d2_wv_pre;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  sync_fifo_ctrl #(.DATA_W(8), .DEPTH(4), .FWFT(1'b0), .AF_LEVEL(3), .AE_LEVEL(1)) dut0 (
    .clock(clock), .reset(reset), .io_flush(flush),
    .io_wrReq_en(wr_en), .io_wrReq_data(wr_data), .io_wrReq_valid(d0_wv),
    .io_full(d0_full), .io_almostFull(d0_af),
    .io_rdReq_en(rd_en), .io_rdReq_data(d0_rd), .io_rdReq_valid(d0_rv),
    .io_empty(d0_empty), .io_almostEmpty(d0_ae), .io_count(d0_cnt),
    .io_overflow(d0_ovf), .io_underflow(d0_udf)
  );

  sync_fifo_ctrl #(.DATA_W(8), .DEPTH(4), .FWFT(1'b1), .AF_LEVEL(3), .AE_LEVEL(1)) dut1 (
    .clock(clock), .reset(reset), .io_flush(flush),
    .io_wrReq_en(wr_en), .io_wrReq_data(wr_data), .io_wrReq_valid(d1_wv),
    .io_full(d1_full), .io_almostFull(d1_af),
    .io_rdReq_en(rd_en), .io_rdReq_data(d1_rd), .io_rdReq_valid(d1_rv),
    .io_empty(d1_empty), .io_almostEmpty(d1_ae), .io_count(d1_cnt),
    .io_overflow(d1_ovf), .io_underflow(d1_udf)
  );

  sync_fifo_ctrl #(.DATA_W(8), .DEPTH(5), .FWFT(1'b0), .AF_LEVEL(3), .AE_LEVEL(1)) dut2 (
    .clock(clock), .reset(reset), .io_flush(flush),
    .io_wrReq_en(wr_en), .io_wrReq_data(wr_data), .io_wrReq_valid(d2_wv),
    .io_full(d2_full), .io_almostFull(d2_af),
    .io_rdReq_en(rd_en), .io_rdReq_data(d2_rd), .io_rdReq_valid(d2_rv),
    .io_empty(d2_empty), .io_almostEmpty(d2_ae), .io_count(d2_cnt),
    .io_overflow(d2_ovf), .io_underflow(d2_udf)
  );

  typedef struct {
    logic       flush, we;
    logic [7:0] wd;
    logic       re;
    logic       wv;
    logic [2:0] cnt;
    logic       full, af, empty, ae, rv;
    logic [7:0] rd;
    logic       ovf, udf;
  } vec_t;

  vec_t vt[12];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Drive inputs, sample the combinational accept flag before the edge, then move to #1
  // after the edge so registered outputs can be compared.
  task automatic step(input logic f, input logic we, input logic [7:0] wd, input logic re);
    flush   = f;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    #1;
    d0_wv_pre = d0_wv;
    d1_wv_pre = d1_wv;
    d2_wv_pre = d2_wv;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_d0_vec(int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    chk({t, " wrReq_valid"}, 32'(d0_wv_pre), 32'(vt[idx].wv));
    chk({t, " count"},       32'(d0_cnt),    32'(vt[idx].cnt));
    chk({t, " full"},        32'(d0_full),   32'(vt[idx].full));
    chk({t, " almostFull"},  32'(d0_af),     32'(vt[idx].af));
    chk({t, " empty"},       32'(d0_empty),  32'(vt[idx].empty));
    chk({t, " almostEmpty"}, 32'(d0_ae),     32'(vt[idx].ae));
    chk({t, " rdReq_valid"}, 32'(d0_rv),     32'(vt[idx].rv));
    chk({t, " rdReq_data"},  32'(d0_rd),     32'(vt[idx].rd));
    chk({t, " overflow"},    32'(d0_ovf),    32'(vt[idx].ovf));
    chk({t, " underflow"},   32'(d0_udf),    32'(vt[idx].udf));
  endtask

  // Reference model for dut2: a plain queue of accepted words plus flag bits.
  localparam int MD = 5;
  logic [7:0] mq[$];
  logic       m_rv, m_ovf, m_udf;
  logic [7:0] m_rd;

  task automatic model_reset();
    mq.delete();
    m_rv  = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rd  = 8'h00;
  endtask

  task automatic chk_d2(string t);
    chk({t, " count"},       32'(d2_cnt),   32'(mq.size()));
    chk({t, " full"},        32'(d2_full),  32'(mq.size() == MD));
    chk({t, " almostFull"},  32'(d2_af),    32'(mq.size() >= 3));
    chk({t, " empty"},       32'(d2_empty), 32'(mq.size() == 0));
    chk({t, " almostEmpty"}, 32'(d2_ae),    32'(mq.size() <= 1));
    chk({t, " rdReq_valid"}, 32'(d2_rv),    32'(m_rv));
    chk({t, " rdReq_data"},  32'(d2_rd),    32'(m_rd));
    chk({t, " overflow"},    32'(d2_ovf),   32'(m_ovf));
    chk({t, " underflow"},   32'(d2_udf),   32'(m_udf));
    chk({t, " count<=5"},    32'(d2_cnt <= 3'd5), 32'd1);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop without waiting for an edge.
  task automatic reset_pulse(string t);
    #3;
    reset = 1'b0;
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    model_reset();
    chk_d2(t);
    chk({t, " d0 count"}, 32'(d0_cnt), 32'd0);
    chk({t, " d0 rdReq_valid"}, 32'(d0_rv), 32'd0);
    chk({t, " d1 rdReq_valid"}, 32'(d1_rv), 32'd0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // flush, we, wd, re | wv, cnt, full, af, empty, ae, rv, rd, ovf, udf
    vt[0]  = '{O, I, 8'h11, O, I, 3'd1, O, O, O, I, O, 8'h00, O, O};
    vt[1]  = '{O, I, 8'h22, O, I, 3'd2, O, O, O, O, O, 8'h00, O, O};
    vt[2]  = '{O, I, 8'h33, O, I, 3'd3, O, I, O, O, O, 8'h00, O, O};
    vt[3]  = '{O, I, 8'h44, O, I, 3'd4, I, I, O, O, O, 8'h00, O, O};
    vt[4]  = '{O, I, 8'h55, O, O, 3'd4, I, I, O, O, O, 8'h00, I, O};
    vt[5]  = '{O, O, 8'h00, I, O, 3'd3, O, I, O, O, I, 8'h11, I, O};
    vt[6]  = '{O, O, 8'h00, I, O, 3'd2, O, O, O, O, I, 8'h22, I, O};
    vt[7]  = '{O, O, 8'h00, I, O, 3'd1, O, O, O, I, I, 8'h33, I, O};
    vt[8]  = '{O, O, 8'h00, I, O, 3'd0, O, O, I, I, I, 8'h44, I, O};
    vt[9]  = '{O, O, 8'h00, I, O, 3'd0, O, O, I, I, O, 8'h44, I, I};
    vt[10] = '{O, O, 8'h00, O, O, 3'd0, O, O, I, I, O, 8'h44, I, I};
    vt[11] = '{I, I, 8'h66, I, O, 3'd0, O, O, I, I, O, 8'h44, O, O};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("reset d0 count", 32'(d0_cnt), 32'd0);
    chk("reset d0 empty", 32'(d0_empty), 32'd1);
    chk("reset d0 almostEmpty", 32'(d0_ae), 32'd1);
    chk("reset d0 full", 32'(d0_full), 32'd0);
    chk("reset d0 almostFull", 32'(d0_af), 32'd0);
    chk("reset d0 rdReq_valid", 32'(d0_rv), 32'd0);
    chk("reset d0 rdReq_data", 32'(d0_rd), 32'd0);
    chk("reset d0 overflow", 32'(d0_ovf), 32'd0);
    chk("reset d0 underflow", 32'(d0_udf), 32'd0);
    chk("reset d1 rdReq_valid", 32'(d1_rv), 32'd0);
    chk("reset d1 rdReq_data", 32'(d1_rd), 32'd0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;

    // Fill, overflow, drain, underflow, flush on the standard-read FIFO
    for (int i = 0; i < 12; i++) begin
      step(vt[i].flush, vt[i].we, vt[i].wd, vt[i].re);
      chk_d0_vec(i);
    end

    // Simultaneous push/pop at count 2 across pointer wrap
    step(O, I, 8'hA0, O);
    step(O, I, 8'hA1, O);
    for (int k = 0; k < 10; k++) begin
      step(O, I, 8'(8'hA2 + k), I);
      chk($sformatf("rw%0d count", k), 32'(d0_cnt), 32'd2);
      chk($sformatf("rw%0d rdReq_valid", k), 32'(d0_rv), 32'd1);
      chk($sformatf("rw%0d rdReq_data", k), 32'(d0_rd), 32'(8'(8'hA0 + k)));
    end

    // Count 3 with overflow set, then flush with both requests
    step(I, O, 8'h00, O);
    for (int k = 0; k < 5; k++) step(O, I, 8'(8'hB0 + k), O);
    step(O, O, 8'h00, I);
    chk("pre-flush count", 32'(d0_cnt), 32'd3);
    chk("pre-flush overflow", 32'(d0_ovf), 32'd1);
    step(I, I, 8'hCC, I);
    chk("flush wrReq_valid", 32'(d0_wv_pre), 32'd0);
    chk("flush count", 32'(d0_cnt), 32'd0);
    chk("flush empty", 32'(d0_empty), 32'd1);
    chk("flush overflow", 32'(d0_ovf), 32'd0);
    chk("flush underflow", 32'(d0_udf), 32'd0);
    chk("flush rdReq_valid", 32'(d0_rv), 32'd0);
    chk("flush rdReq_data held", 32'(d0_rd), 32'hB0);
    step(O, O, 8'h00, O);
    chk("post-flush count", 32'(d0_cnt), 32'd0);

    // FWFT: word falls through without a read, pop empties
    step(O, I, 8'hA5, O);
    chk("fwft valid", 32'(d1_rv), 32'd1);
    chk("fwft data", 32'(d1_rd), 32'hA5);
    step(O, O, 8'h00, O);
    chk("fwft hold valid", 32'(d1_rv), 32'd1);
    chk("fwft hold data", 32'(d1_rd), 32'hA5);
    step(O, O, 8'h00, I);
    chk("fwft pop empty", 32'(d1_empty), 32'd1);
    chk("fwft pop valid", 32'(d1_rv), 32'd0);
    step(O, I, 8'hC1, O);
    step(O, I, 8'hC2, O);
    chk("fwft head1", 32'(d1_rd), 32'hC1);
    step(O, O, 8'h00, I);
    chk("fwft head2", 32'(d1_rd), 32'hC2);
    chk("fwft count", 32'(d1_cnt), 32'd1);

    // Randomized push/pop on DEPTH=5 against the queue model, with async resets
    reset_pulse("rst0");
    for (int c = 0; c < 120; c++) begin
      logic f, we, re, exp_wv;
      logic [7:0] wd;
      int sz;
      f  = ($urandom_range(0, 15) == 0);
      we = ($urandom_range(0, 9) < 6);
      re = ($urandom_range(0, 9) < 5);
      wd = 8'($urandom);
      sz = mq.size();
      exp_wv = we && !f && (sz < MD);
      step(f, we, wd, re);
      chk($sformatf("rnd%0d wrReq_valid", c), 32'(d2_wv_pre), 32'(exp_wv));
      if (f) begin
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_rv  = 1'b0;
      end else begin
        if (we && sz == MD) m_ovf = 1'b1;
        if (re && sz == 0) m_udf = 1'b1;
        m_rv = re && (sz > 0);
        if (m_rv) m_rd = mq.pop_front();
        if (exp_wv) mq.push_back(wd);
      end
      chk_d2($sformatf("rnd%0d", c));
      if (c == 60) reset_pulse("rst_mid");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
